axis_vid_pixel_unpack: RTL and testbench

// - AXI4-Stream video pixel unpacker: takes 32-bit packed framebuffer words from the VDMA-side stream.
// - Emits one 32-bit {ALPHA_FILL,R8,G8,B8} pixel per output beat to the video timing/output stream.
// - Successor to the fixed RGB565 expander: selectable source format, 1/2/4 pixels per word.
// - Full AXIS back-pressure handling; tuser/tlast aligned to the correct sub-pixel.

---
 rtl/axis_vid_pixel_unpack.sv | 187 ++++++++++++++++++
 tb/tb_axis_vid_pixel_unpack.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_vid_pixel_unpack.sv
// AXI4-Stream video pixel unpacker.
// Splits 32-bit packed framebuffer words into one {ALPHA_FILL,R8,G8,B8} pixel per beat.
// Supported source formats: RGB565 x2, XRGB8888 x1, 8bpp x4 and RGB555 x2.
module axis_vid_pixel_unpack #(
  parameter logic [7:0] ALPHA_FILL = 8'h00,
  parameter bit         SWAP_RB    = 1'b0,
  parameter bit         GREY_MODE  = 1'b1
) (
  input  logic        axis_vid_aclk,
  input  logic        axis_vid_reset,
  input  logic [1:0]  mode,
  input  logic [31:0] m_axis_vid_tdata,
  input  logic        m_axis_vid_tvalid,
  output logic        m_axis_vid_tready,
  input  logic        m_axis_vid_tuser,
  input  logic        m_axis_vid_tlast,
  output logic [31:0] s_axis_vid_tdata,
  output logic        s_axis_vid_tvalid,
  input  logic        s_axis_vid_tready,
  output logic        s_axis_vid_tuser,
  output logic        s_axis_vid_tlast
);

  typedef enum logic {EMPTY = 1'b0, EMIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  mode_q, mode_d;
  logic        user_q, user_d;
  logic        last_q, last_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] pixOut_q, pixOut_d;
  logic        userOut_q, userOut_d;
  logic        lastOut_q, lastOut_d;

  logic        lastPix;
  logic        fire;
  logic        accept;
  logic        inReady;
  logic [1:0]  nextIdx;

  // Widen a 5-bit colour channel to 8 bits by replicating its MSBs.
  function automatic logic [7:0] rep5(input logic [4:0] c);
    return {c, c[4:2]};
  endfunction

  // Widen a 6-bit colour channel to 8 bits by replicating its MSBs.
  function automatic logic [7:0] rep6(input logic [5:0] c);
    return {c, c[5:4]};
  endfunction

  // Index of the final sub-pixel for a given format (pixels per word minus one).
  function automatic logic [1:0] lastIdxOf(input logic [1:0] md);
    logic [1:0] li;
    case (md)
      2'd1:    li = 2'd0;
      2'd2:    li = 2'd3;
      default: li = 2'd1;
    endcase
    return li;
  endfunction

  // Extract sub-pixel idx of a packed word and expand it to the output pixel format.
  function automatic logic [31:0] expandPixel(input logic [31:0] word,
                                              input logic [1:0]  md,
                                              input logic [1:0]  idx);
    logic [15:0] half;
    logic [7:0]  byteV;
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    half = idx[0] ? word[31:16] : word[15:0];
    case (idx)
      2'd0:    byteV = word[7:0];
      2'd1:    byteV = word[15:8];
      2'd2:    byteV = word[23:16];
      default: byteV = word[31:24];
    endcase
    case (md)
      2'd0: begin
        r8 = rep5(half[4:0]);
        g8 = rep6(half[10:5]);
        b8 = rep5(half[15:11]);
      end
      2'd1: begin
        r8 = word[7:0];
        g8 = word[15:8];
        b8 = word[23:16];
      end
      2'd2: begin
        if (GREY_MODE) begin
          r8 = byteV;
          g8 = byteV;
        end else begin
          r8 = 8'h00;
          g8 = 8'h00;
        end
        b8 = byteV;
      end
      default: begin
        r8 = rep5(half[4:0]);
        g8 = rep5(half[9:5]);
        b8 = rep5(half[14:10]);
      end
    endcase
    if (SWAP_RB) begin
      return {ALPHA_FILL, b8, g8, r8};
    end
    return {ALPHA_FILL, r8, g8, b8};
  endfunction

  // Handshake decode and next-state selection: a new word may land in the same cycle
  // the held word's final pixel leaves, which keeps back-to-back words at one pixel per clock.
  always_comb begin
    lastPix   = (idx_q == lastIdxOf(mode_q));
    fire      = (state_q == EMIT) && s_axis_vid_tready;
    inReady   = (state_q == EMPTY) || (s_axis_vid_tready && lastPix);
    accept    = m_axis_vid_tvalid && inReady;
    nextIdx   = idx_q + 2'd1;

    state_d   = state_q;
    data_d    = data_q;
    mode_d    = mode_q;
    user_d    = user_q;
    last_d    = last_q;
    idx_d     = idx_q;
    pixOut_d  = pixOut_q;
    userOut_d = userOut_q;
    lastOut_d = lastOut_q;

    if (accept) begin
      state_d   = EMIT;
      data_d    = m_axis_vid_tdata;
      mode_d    = mode;
      user_d    = m_axis_vid_tuser;
      last_d    = m_axis_vid_tlast;
      idx_d     = 2'd0;
      pixOut_d  = expandPixel(m_axis_vid_tdata, mode, 2'd0);
      userOut_d = m_axis_vid_tuser;
      lastOut_d = m_axis_vid_tlast && (lastIdxOf(mode) == 2'd0);
    end else if (fire) begin
      if (lastPix) begin
        state_d   = EMPTY;
        idx_d     = 2'd0;
        userOut_d = 1'b0;
        lastOut_d = 1'b0;
      end else begin
        idx_d     = nextIdx;
        pixOut_d  = expandPixel(data_q, mode_q, nextIdx);
        userOut_d = 1'b0;
        lastOut_d = last_q && (nextIdx == lastIdxOf(mode_q));
      end
    end
  end

  // Word register, sub-pixel index and registered output beat; reset drops any held word.
  always_ff @(posedge axis_vid_aclk) begin
    if (axis_vid_reset) begin
      state_q   <= EMPTY;
      data_q    <= 32'h0;
      mode_q    <= 2'd0;
      user_q    <= 1'b0;
      last_q    <= 1'b0;
      idx_q     <= 2'd0;
      pixOut_q  <= 32'h0;
      userOut_q <= 1'b0;
      lastOut_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      mode_q    <= mode_d;
      user_q    <= user_d;
      last_q    <= last_d;
      idx_q     <= idx_d;
      pixOut_q  <= pixOut_d;
      userOut_q <= userOut_d;
      lastOut_q <= lastOut_d;
    end
  end

  assign m_axis_vid_tready = inReady;
  assign s_axis_vid_tvalid = (state_q == EMIT);
  assign s_axis_vid_tdata  = pixOut_q;
  assign s_axis_vid_tuser  = userOut_q;
  assign s_axis_vid_tlast  = lastOut_q;

endmodule

// File: tb/tb_axis_vid_pixel_unpack.sv
// Testbench for axis_vid_pixel_unpack (default parameters).
// A queue holds the pixels the currently held word should still produce.
module tb_axis_vid_pixel_unpack;

  localparam logic [7:0] ALPHA = 8'h00;
  localparam bit         GREY  = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [31:0] inData;
  logic        inValid;
  logic        inReady;
  logic        inUser;
  logic        inLast;
  logic [31:0] outData;
  logic        outValid;
  logic        outReady;
  logic        outUser;
  logic        outLast;

  int          checks = 0;
  int          failures = 0;
  logic [33:0] expQ[$];
  logic        prevStall = 1'b0;
  logic [33:0] prevOut = '0;
  int          cycleCount = 0;

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  axis_vid_pixel_unpack dut (
    .axis_vid_aclk     (clk),
    .axis_vid_reset    (rst),
    .mode              (mode),
    .m_axis_vid_tdata  (inData),
    .m_axis_vid_tvalid (inValid),
    .m_axis_vid_tready (inReady),
    .m_axis_vid_tuser  (inUser),
    .m_axis_vid_tlast  (inLast),
    .s_axis_vid_tdata  (outData),
    .s_axis_vid_tvalid (outValid),
    .s_axis_vid_tready (outReady),
    .s_axis_vid_tuser  (outUser),
    .s_axis_vid_tlast  (outLast)
  );

  // Scale an n-bit channel value to 8 bits by MSB replication, using plain arithmetic.
  function automatic int scaleTo8(input int v, input int bits);
    return (bits == 5) ? (v * 8 + v / 4) : (v * 4 + v / 16);
  endfunction

  // Append the beats an accepted word should produce, as {tuser, tlast, tdata}.
  function automatic void modelWord(input logic [31:0] w, input logic [1:0] md,
                                    input logic u, input logic l);
    int n;
    int p;
    int r;
    int g;
    int b;
    logic [31:0] pix;
    n = (md == 2'd1) ? 1 : (md == 2'd2) ? 4 : 2;
    for (int i = 0; i < n; i++) begin
      p = int'((w >> (16 * i)) & 32'hFFFF);
      case (md)
        2'd0: begin
          r = scaleTo8(p & 31, 5);
          g = scaleTo8((p >> 5) & 63, 6);
          b = scaleTo8((p >> 11) & 31, 5);
        end
        2'd1: begin
          r = int'(w & 32'hFF);
          g = int'((w >> 8) & 32'hFF);
          b = int'((w >> 16) & 32'hFF);
        end
        2'd2: begin
          b = int'((w >> (8 * i)) & 32'hFF);
          r = GREY ? b : 0;
          g = GREY ? b : 0;
        end
        default: begin
          r = scaleTo8(p & 31, 5);
          g = scaleTo8((p >> 5) & 31, 5);
          b = scaleTo8((p >> 10) & 31, 5);
        end
      endcase
      pix = {ALPHA, 8'(r), 8'(g), 8'(b)};
      expQ.push_back({u && (i == 0), l && (i == n - 1), pix});
    end
  endfunction

  // Single comparison point: counts the check and reports any difference.
  task automatic checkOutput(input string tag, input logic [33:0] obs, input logic [33:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one clock cycle of inputs, check outputs mid-cycle, and update the model.
  task automatic applyStimulus(input logic r, input logic tv, input logic [31:0] td,
                               input logic [1:0] md, input logic tu, input logic tl,
                               input logic sr, output logic acc);
    rst      = r;
    inValid  = tv;
    inData   = td;
    mode     = md;
    inUser   = tu;
    inLast   = tl;
    outReady = sr;
    @(negedge clk);
    acc = 1'b0;
    if (!r) begin
      checkOutput("tvalid", {33'b0, outValid}, {33'b0, expQ.size() != 0});
      checkOutput("m_tready", {33'b0, inReady},
                  {33'b0, (expQ.size() == 0) || (sr && expQ.size() == 1)});
      if (prevStall) checkOutput("stall_hold", {outUser, outLast, outData}, prevOut);
      if (outValid && sr && expQ.size() > 0)
        checkOutput("pixel", {outUser, outLast, outData}, expQ.pop_front());
      acc = tv && inReady;
      if (acc) modelWord(td, md, tu, tl);
      prevStall = outValid && !sr;
      prevOut   = {outUser, outLast, outData};
    end else begin
      expQ.delete();
      prevStall = 1'b0;
    end
    @(posedge clk);
    #1;
    cycleCount++;
  endtask

  initial begin
    logic        a;
    logic [31:0] w;
    logic        sr;

    // Reset and reset-state check.
    applyStimulus(1, 0, 32'h0, 2'd0, 0, 0, 0, a);
    applyStimulus(1, 0, 32'h0, 2'd0, 0, 0, 0, a);
    checkOutput("rst_tvalid", {33'b0, outValid}, 34'd0);
    checkOutput("rst_tready", {33'b0, inReady}, 34'd1);
    checkOutput("rst_beat", {outUser, outLast, outData}, 34'd0);

    // RGB565 pair with start of frame.
    applyStimulus(0, 1, 32'hFFFF_0000, 2'd0, 1, 0, 1, a);
    checkOutput("m0_p0", {outUser, outLast, outData}, {2'b10, 32'h0000_0000});
    applyStimulus(0, 0, 32'h0, 2'd0, 0, 0, 1, a);
    checkOutput("m0_p1", {outUser, outLast, outData}, {2'b00, 32'h00FF_FFFF});
    applyStimulus(0, 0, 32'h0, 2'd0, 0, 0, 1, a);

    // XRGB8888 single pixel with end of line.
    applyStimulus(0, 1, 32'hAB12_3456, 2'd1, 0, 1, 1, a);
    checkOutput("m1_p0", {outUser, outLast, outData}, {2'b01, 32'h0056_3412});
    applyStimulus(0, 0, 32'h0, 2'd0, 0, 0, 1, a);

    // 8bpp grey, four beats; tready is checked every cycle.
    applyStimulus(0, 1, 32'h8040_2010, 2'd2, 0, 1, 1, a);
    checkOutput("m2_p0", {outUser, outLast, outData}, {2'b00, 32'h0010_1010});
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 32'h0, 2'd0, 0, 0, 1, a);

    // Back-pressure: eight RGB565 words, downstream ready toggling every two cycles.
    for (int k = 0; k < 8; k++) begin
      w = $urandom;
      a = 1'b0;
      for (int t = 0; t < 20 && !a; t++) begin
        sr = ((cycleCount / 2) % 2) == 0;
        applyStimulus(0, 1, w, 2'd0, k == 0, 1, sr, a);
      end
      checkOutput("bp_accept", {33'b0, a}, 34'd1);
    end
    for (int t = 0; t < 12; t++) begin
      sr = ((cycleCount / 2) % 2) == 0;
      applyStimulus(0, 0, 32'h0, 2'd0, 0, 0, sr, a);
    end
    checkOutput("bp_drained", 34'(expQ.size()), 34'd0);

    // Reset after the first pixel of an 8bpp word.
    applyStimulus(0, 1, 32'h4433_2211, 2'd2, 1, 1, 1, a);
    applyStimulus(0, 0, 32'h0, 2'd0, 0, 0, 1, a);
    applyStimulus(1, 0, 32'h0, 2'd0, 0, 0, 1, a);
    checkOutput("midrst_tvalid", {33'b0, outValid}, 34'd0);
    checkOutput("midrst_tready", {33'b0, inReady}, 34'd1);
    applyStimulus(0, 1, 32'hDDCC_BBAA, 2'd2, 0, 1, 1, a);
    checkOutput("midrst_p0", {outUser, outLast, outData}, {2'b00, 32'h00AA_AAAA});
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 32'h0, 2'd0, 0, 0, 1, a);

    // Mode pin changes while an RGB565 word is still being emitted.
    applyStimulus(0, 1, 32'h1234_5678, 2'd0, 0, 1, 0, a);
    applyStimulus(0, 1, 32'h00C0_FFEE, 2'd1, 0, 1, 0, a);
    applyStimulus(0, 1, 32'h00C0_FFEE, 2'd1, 0, 1, 1, a);
    applyStimulus(0, 1, 32'h00C0_FFEE, 2'd1, 0, 1, 1, a);
    checkOutput("modesw_accept", {33'b0, a}, 34'd1);
    applyStimulus(0, 0, 32'h0, 2'd0, 0, 0, 1, a);
    checkOutput("modesw_drained", 34'(expQ.size()), 34'd0);

    // RGB555 directed word.
    applyStimulus(0, 1, 32'hFFFF_7C1F, 2'd3, 0, 0, 1, a);
    checkOutput("m3_p0", {outUser, outLast, outData}, {2'b00, 32'h00FF_00FF});
    applyStimulus(0, 0, 32'h0, 2'd0, 0, 0, 1, a);
    applyStimulus(0, 0, 32'h0, 2'd0, 0, 0, 1, a);

    // Randomised traffic across all formats and handshake patterns.
    for (int t = 0; t < 400; t++) begin
      applyStimulus(0, 1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) != 0), a);
    end
    for (int t = 0; t < 8; t++) applyStimulus(0, 0, 32'h0, 2'd0, 0, 0, 1, a);
    checkOutput("final_drained", 34'(expQ.size()), 34'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
